// File: rtl/measure_sequencer.sv
// Measurement sweep sequencer: for each mode writes the range/keys register,
// turns the sine generator on, steps through the mode's mux channels, waits
// for the signal to settle, runs one ADC conversion per channel and pushes
// the tagged result into a FIFO. All outputs are registered.
module measure_sequencer #(
    parameter int NUM_MODES      = 5,
    parameter int CH_PER_MODE    = 2,
    parameter int MUX_W          = 3,
    parameter int CFG_W          = 8,
    parameter int SETTLE_PERIODS = 2,
    parameter int DATA_W         = 24
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               gen_new_period,
    input  logic [NUM_MODES*CFG_W-1:0]         mode_cfg,
    input  logic [NUM_MODES*CH_PER_MODE*MUX_W-1:0] mode_mux,
    output logic                               reg_start,
    output logic [CFG_W-1:0]                   reg_data,
    input  logic                               reg_done,
    output logic [1:0]                         cs_sel,
    output logic                               gen_enable,
    output logic [MUX_W-1:0]                   mux_chn,
    output logic                               adc_start,
    input  logic                               adc_complete,
    input  logic [DATA_W-1:0]                  adc_data,
    output logic                               fifo_wr,
    output logic [DATA_W+7:0]                  fifo_data,
    input  logic                               fifo_full,
    output logic                               busy,
    output logic                               sweep_done,
    output logic                               overrun
);

    typedef enum logic [3:0] {
        IDLE, SET_REG, WAIT_REG, GEN_ON, SET_MUX, SETTLE,
        START_ADC, WAIT_ADC, PUSH, GEN_OFF, NEXT
    } state_t;

    localparam logic [3:0] LAST_MODE   = 4'(NUM_MODES - 1);
    localparam logic [3:0] LAST_CH     = 4'(CH_PER_MODE - 1);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_PERIODS);

    localparam logic [1:0] CS_NONE = 2'd3;
    localparam logic [1:0] CS_REG  = 2'd2;
    localparam logic [1:0] CS_DAC  = 2'd1;

    state_t      state, state_nxt;
    logic [3:0]  mode, mode_nxt;
    logic [3:0]  ch, ch_nxt;
    logic [7:0]  settle, settle_nxt;
    logic        abort, abort_nxt;

    logic              reg_start_d, gen_enable_d, adc_start_d, fifo_wr_d;
    logic              busy_d, sweep_done_d, overrun_d;
    logic [1:0]        cs_sel_d;
    logic [CFG_W-1:0]  reg_data_d;
    logic [MUX_W-1:0]  mux_chn_d;
    logic [DATA_W+7:0] fifo_data_d;

    // Flat configuration buses unpacked into full 16-entry tables so that the
    // 4-bit mode/channel counters index them without width adaptation; unused
    // slots read as zero.
    logic [CFG_W-1:0] cfg_arr [16];
    logic [MUX_W-1:0] mux_arr [16][16];

    for (genvar m = 0; m < 16; m++) begin : g_mode
        if (m < NUM_MODES) begin : g_cfg_used
            assign cfg_arr[m] = mode_cfg[m*CFG_W +: CFG_W];
        end else begin : g_cfg_unused
            assign cfg_arr[m] = '0;
        end
        for (genvar c = 0; c < 16; c++) begin : g_ch
            if (m < NUM_MODES && c < CH_PER_MODE) begin : g_mux_used
                assign mux_arr[m][c] = mode_mux[(m*CH_PER_MODE+c)*MUX_W +: MUX_W];
            end else begin : g_mux_unused
                assign mux_arr[m][c] = '0;
            end
        end
    end

    // State register and sweep position counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state  <= IDLE;
            mode   <= '0;
            ch     <= '0;
            settle <= '0;
            abort  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode   <= mode_nxt;
            ch     <= ch_nxt;
            settle <= settle_nxt;
            abort  <= abort_nxt;
        end
    end

    // Next-state and counter update logic; a stop request routes through
    // GEN_OFF with abort set so the sweep ends without sweep_done.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt  = state;
        mode_nxt   = mode;
        ch_nxt     = ch;
        settle_nxt = settle;
        abort_nxt  = abort;
        case (state)
            IDLE: begin
                if (enable && gen_new_period) begin
                    state_nxt = SET_REG;
                    mode_nxt  = '0;
                    ch_nxt    = '0;
                    abort_nxt = 1'b0;
                end
            end
            SET_REG: state_nxt = WAIT_REG;
            WAIT_REG: begin
                if (reg_done) begin
                    if (enable) begin
                        state_nxt = GEN_ON;
                    end else begin
                        state_nxt = GEN_OFF;
                        abort_nxt = 1'b1;
                    end
                end
            end
            GEN_ON: begin
                if (!enable) begin
                    state_nxt = GEN_OFF;
                    abort_nxt = 1'b1;
                end else begin
                    state_nxt = SET_MUX;
                end
            end
            SET_MUX: begin
                if (!enable) begin
                    state_nxt = GEN_OFF;
                    abort_nxt = 1'b1;
                end else begin
                    state_nxt  = SETTLE;
                    settle_nxt = SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_nxt = GEN_OFF;
                    abort_nxt = 1'b1;
                end else if (gen_new_period) begin
                    if (settle == 8'd0) begin
                        state_nxt = START_ADC;
                    end else begin
                        settle_nxt = settle - 8'd1;
                    end
                end
            end
            START_ADC: begin
                if (!enable) begin
                    state_nxt = GEN_OFF;
                    abort_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT_ADC;
                end
            end
            WAIT_ADC: begin
                if (adc_complete) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    if (!enable) begin
                        state_nxt = GEN_OFF;
                        abort_nxt = 1'b1;
                    end else if (ch < LAST_CH) begin
                        ch_nxt    = ch + 4'd1;
                        state_nxt = SET_MUX;
                    end else begin
                        state_nxt = GEN_OFF;
                    end
                end
            end
            GEN_OFF: state_nxt = abort ? IDLE : NEXT;
            NEXT: begin
                if (!enable) begin
                    state_nxt = GEN_OFF;
                    abort_nxt = 1'b1;
                end else if (mode < LAST_MODE) begin
                    mode_nxt  = mode + 4'd1;
                    ch_nxt    = '0;
                    state_nxt = SET_REG;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up
    // with the state they belong to.
    always_comb begin
        reg_start_d  = (state_nxt == SET_REG);
        adc_start_d  = (state_nxt == START_ADC);
        busy_d       = (state_nxt != IDLE);
        fifo_wr_d    = (state == PUSH) && !fifo_full;
        sweep_done_d = (state == NEXT) && enable && (mode == LAST_MODE);
        overrun_d    = overrun || (adc_complete && (state != WAIT_ADC));
        reg_data_d   = (state_nxt == SET_REG) ? cfg_arr[mode_nxt] : reg_data;
        fifo_data_d  = (state == WAIT_ADC && adc_complete) ? {mode, ch, adc_data} : fifo_data;

        mux_chn_d = mux_chn;
        if (state_nxt == SET_MUX) begin
            mux_chn_d = mux_arr[mode_nxt][ch_nxt];
        end else if (state_nxt == GEN_OFF) begin
            mux_chn_d = '0;
        end

        cs_sel_d     = CS_NONE;
        gen_enable_d = 1'b0;
        case (state_nxt)
            SET_REG, WAIT_REG: cs_sel_d = CS_REG;
            GEN_ON, SET_MUX, SETTLE, START_ADC, WAIT_ADC, PUSH: begin
                cs_sel_d     = CS_DAC;
                gen_enable_d = 1'b1;
            end
            default: begin
                cs_sel_d     = CS_NONE;
                gen_enable_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_start  <= 1'b0;
            reg_data   <= '0;
            cs_sel     <= CS_NONE;
            gen_enable <= 1'b0;
            mux_chn    <= '0;
            adc_start  <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            reg_start  <= reg_start_d;
            reg_data   <= reg_data_d;
            cs_sel     <= cs_sel_d;
            gen_enable <= gen_enable_d;
            mux_chn    <= mux_chn_d;
            adc_start  <= adc_start_d;
            fifo_wr    <= fifo_wr_d;
            fifo_data  <= fifo_data_d;
            busy       <= busy_d;
            sweep_done <= sweep_done_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer: a full sweep with ideal SPI/ADC,
// settle timing for two SETTLE_PERIODS values, FIFO back-pressure, stop
// request mid-sweep, overrun flag and reset during a register write.
module tb_measure_sequencer;

    localparam int NM = 5;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        gen_new_period = 1'b0;
    logic [NM*8-1:0]    mode_cfg = '0;
    logic [NM*NC*3-1:0] mode_mux = '0;
    logic        fifo_full_a = 1'b0;
    logic        inject = 1'b0;
    logic        rd_hold = 1'b0;

    logic        reg_start_a, reg_done_a = 1'b0, gen_enable_a, adc_start_a;
    logic        adc_pulse_a = 1'b0, adc_complete_a, fifo_wr_a, busy_a, sweep_done_a, overrun_a;
    logic [7:0]  reg_data_a;
    logic [1:0]  cs_sel_a;
    logic [2:0]  mux_chn_a;
    logic [23:0] adc_data_a = '0;
    logic [31:0] fifo_data_a;

    logic        reg_start_b, reg_done_b = 1'b0, gen_enable_b, adc_start_b;
    logic        adc_complete_b = 1'b0, fifo_wr_b, busy_b, sweep_done_b, overrun_b;
    logic [7:0]  reg_data_b;
    logic [1:0]  cs_sel_b;
    logic [2:0]  mux_chn_b;
    logic [23:0] adc_data_b = '0;
    logic [31:0] fifo_data_b;

    assign adc_complete_a = adc_pulse_a | inject;

    measure_sequencer #(.SETTLE_PERIODS(2)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .gen_new_period(gen_new_period),
        .mode_cfg(mode_cfg), .mode_mux(mode_mux),
        .reg_start(reg_start_a), .reg_data(reg_data_a), .reg_done(reg_done_a),
        .cs_sel(cs_sel_a), .gen_enable(gen_enable_a), .mux_chn(mux_chn_a),
        .adc_start(adc_start_a), .adc_complete(adc_complete_a), .adc_data(adc_data_a),
        .fifo_wr(fifo_wr_a), .fifo_data(fifo_data_a), .fifo_full(fifo_full_a),
        .busy(busy_a), .sweep_done(sweep_done_a), .overrun(overrun_a)
    );

    measure_sequencer #(.SETTLE_PERIODS(0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .gen_new_period(gen_new_period),
        .mode_cfg(mode_cfg), .mode_mux(mode_mux),
        .reg_start(reg_start_b), .reg_data(reg_data_b), .reg_done(reg_done_b),
        .cs_sel(cs_sel_b), .gen_enable(gen_enable_b), .mux_chn(mux_chn_b),
        .adc_start(adc_start_b), .adc_complete(adc_complete_b), .adc_data(adc_data_b),
        .fifo_wr(fifo_wr_b), .fifo_data(fifo_data_b), .fifo_full(1'b0),
        .busy(busy_b), .sweep_done(sweep_done_b), .overrun(overrun_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] mux_code(input int m, input int c);
        return 3'(((m * 2 + c) % 7) + 1);
    endfunction

    // Generator and SPI/ADC responders, driven on the falling edge.
    int          gcnt = 0;
    int          rd_dly_a = 0, ad_dly_a = 0, rd_dly_b = 0, ad_dly_b = 0;
    logic [15:0] adc_seq_a = '0;
    always @(negedge clk) begin
        gcnt = (gcnt == 7) ? 0 : gcnt + 1;
        gen_new_period = (gcnt == 0);

        reg_done_a = 1'b0;
        if (rd_dly_a != 0 && !rd_hold) begin
            rd_dly_a--;
            if (rd_dly_a == 0) reg_done_a = 1'b1;
        end
        if (reg_start_a) rd_dly_a = 2;
        adc_pulse_a = 1'b0;
        if (ad_dly_a != 0) begin
            ad_dly_a--;
            if (ad_dly_a == 0) begin
                adc_pulse_a = 1'b1;
                adc_data_a  = {8'hA5, adc_seq_a};
                adc_seq_a++;
            end
        end
        if (adc_start_a) ad_dly_a = 2;

        reg_done_b = 1'b0;
        if (rd_dly_b != 0) begin
            rd_dly_b--;
            if (rd_dly_b == 0) reg_done_b = 1'b1;
        end
        if (reg_start_b) rd_dly_b = 2;
        adc_complete_b = 1'b0;
        if (ad_dly_b != 0) begin
            ad_dly_b--;
            if (ad_dly_b == 0) begin
                adc_complete_b = 1'b1;
                adc_data_b     = adc_data_b + 24'd1;
            end
        end
        if (adc_start_b) ad_dly_b = 2;
    end

    // Event monitor, sampled just after the rising edge.
    logic [31:0] wr_q[$];
    logic [7:0]  rs_q[$];
    logic [2:0]  mux_q[$];
    int          gaps_a[$], gaps_b[$];
    int          gap_a = 0, gap_b = 0, n_done_a = 0;
    always @(posedge clk) begin
        #1;
        if (fifo_wr_a)    wr_q.push_back(fifo_data_a);
        if (reg_start_a)  rs_q.push_back(reg_data_a);
        if (adc_start_a)  mux_q.push_back(mux_chn_a);
        if (sweep_done_a) n_done_a++;
        if (gen_new_period) begin
            gap_a++;
            gap_b++;
        end
        if (adc_start_a) begin
            gaps_a.push_back(gap_a);
            gap_a = 0;
        end
        if (adc_start_b) begin
            gaps_b.push_back(gap_b);
            gap_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_reg_start"},  64'(reg_start_a),  64'd0);
        check({tag, "_adc_start"},  64'(adc_start_a),  64'd0);
        check({tag, "_fifo_wr"},    64'(fifo_wr_a),    64'd0);
        check({tag, "_sweep_done"}, 64'(sweep_done_a), 64'd0);
        check({tag, "_gen_enable"}, 64'(gen_enable_a), 64'd0);
        check({tag, "_cs_sel"},     64'(cs_sel_a),     64'd3);
        check({tag, "_mux_chn"},    64'(mux_chn_a),    64'd0);
        check({tag, "_reg_data"},   64'(reg_data_a),   64'd0);
        check({tag, "_fifo_data"},  64'(fifo_data_a),  64'd0);
        check({tag, "_busy"},       64'(busy_a),       64'd0);
        check({tag, "_overrun"},    64'(overrun_a),    64'd0);
    endtask

    initial begin
        int          g;
        int          rs0, wr0, done0;
        logic [15:0] seq0;
        logic [31:0] exp_w;

        for (int m = 0; m < NM; m++) begin
            mode_cfg[m*8 +: 8] = 8'hC0 + 8'(m);
            for (int c = 0; c < NC; c++) mode_mux[(m*NC+c)*3 +: 3] = mux_code(m, c);
        end
        repeat (3) tick();
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Full sweep on both instances; mode 3 config changed after sweep start.
        @(negedge clk);
        seq0 = adc_seq_a;
        en_a = 1'b1;
        en_b = 1'b1;
        g = 0;
        while (rs_q.size() < 1 && g < 100) begin tick(); g++; end
        check("to_first_reg_start", 64'(rs_q.size() >= 1), 64'd1);
        @(negedge clk);
        mode_cfg[3*8 +: 8] = 8'h5A;
        g = 0;
        while (n_done_a < 1 && g < 3000) begin tick(); g++; end
        check("to_sweep_done", 64'(n_done_a), 64'd1);
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (20) tick();
        check("sweep_words", 64'(wr_q.size()), 64'd10);
        check("sweep_reg_starts", 64'(rs_q.size()), 64'd5);
        check("sweep_done_count", 64'(n_done_a), 64'd1);
        check("idle_after_sweep", 64'(busy_a), 64'd0);
        for (int i = 0; i < 10 && i < wr_q.size(); i++) begin
            exp_w = {4'(i / 2), 4'(i % 2), 8'hA5, 16'(seq0 + 16'(i))};
            check($sformatf("word%0d", i), 64'(wr_q[i]), 64'(exp_w));
            check($sformatf("mux%0d", i), 64'(mux_q[i]), 64'(mux_code(i / 2, i % 2)));
        end
        for (int m = 0; m < 5 && m < rs_q.size(); m++)
            check($sformatf("reg_data_m%0d", m), 64'(rs_q[m]), (m == 3) ? 64'h5A : 64'(8'hC0 + 8'(m)));
        check("settle2_gaps_seen", 64'(gaps_a.size() >= 2), 64'd1);
        check("settle0_gaps_seen", 64'(gaps_b.size() >= 2), 64'd1);
        if (gaps_a.size() >= 2) check("settle2_gap", 64'(gaps_a[1]), 64'd3);
        if (gaps_b.size() >= 2) check("settle0_gap", 64'(gaps_b[1]), 64'd1);

        // FIFO back-pressure on the first word of a new sweep.
        @(negedge clk);
        fifo_full_a = 1'b1;
        en_a = 1'b1;
        rs0  = rs_q.size();
        wr0  = wr_q.size();
        seq0 = adc_seq_a;
        g = 0;
        while (!adc_complete_a && g < 300) begin tick(); g++; end
        check("to_adc_complete", 64'(adc_complete_a), 64'd1);
        exp_w = {8'h00, 8'hA5, seq0};
        check("full_data_latched", 64'(fifo_data_a), 64'(exp_w));
        repeat (20) tick();
        check("full_no_write", 64'(wr_q.size()), 64'(wr0));
        check("full_data_held", 64'(fifo_data_a), 64'(exp_w));
        check("full_busy", 64'(busy_a), 64'd1);
        @(negedge clk);
        fifo_full_a = 1'b0;
        tick();
        tick();
        check("full_one_write", 64'(wr_q.size()), 64'(wr0 + 1));
        if (wr_q.size() > wr0) check("full_write_data", 64'(wr_q[wr0]), 64'(exp_w));

        // Stop request while settling in mode 2.
        g = 0;
        while (rs_q.size() < rs0 + 3 && g < 2000) begin tick(); g++; end
        check("to_mode2_reg", 64'(rs_q.size() >= rs0 + 3), 64'd1);
        g = 0;
        while (!gen_enable_a && g < 50) begin tick(); g++; end
        check("to_mode2_gen_on", 64'(gen_enable_a), 64'd1);
        tick();
        tick();
        check("mode2_mux", 64'(mux_chn_a), 64'(mux_code(2, 0)));
        done0 = n_done_a;
        @(negedge clk);
        en_a = 1'b0;
        tick();
        check("stop_gen_enable", 64'(gen_enable_a), 64'd0);
        check("stop_cs_sel", 64'(cs_sel_a), 64'd3);
        check("stop_mux_chn", 64'(mux_chn_a), 64'd0);
        check("stop_busy_gen_off", 64'(busy_a), 64'd1);
        tick();
        check("stop_busy_idle", 64'(busy_a), 64'd0);
        repeat (10) tick();
        check("stop_no_sweep_done", 64'(n_done_a), 64'(done0));
        check("stop_stays_idle", 64'(busy_a), 64'd0);

        // Stray ADC completion while settling, then reset during WAIT_REG.
        check("overrun_clear", 64'(overrun_a), 64'd0);
        @(negedge clk);
        en_a = 1'b1;
        rs0  = rs_q.size();
        g = 0;
        while (!gen_enable_a && g < 100) begin tick(); g++; end
        check("to_ovr_gen_on", 64'(gen_enable_a), 64'd1);
        tick();
        tick();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        tick();
        check("overrun_set", 64'(overrun_a), 64'd1);
        check("overrun_keeps_running", 64'(gen_enable_a), 64'd1);
        @(negedge clk);
        rd_hold = 1'b1;
        g = 0;
        while (rs_q.size() < rs0 + 2 && g < 500) begin tick(); g++; end
        check("to_mode1_reg", 64'(rs_q.size() >= rs0 + 2), 64'd1);
        tick();
        tick();
        check("overrun_sticky", 64'(overrun_a), 64'd1);
        check("wait_reg_cs_sel", 64'(cs_sel_a), 64'd2);
        check("wait_reg_busy", 64'(busy_a), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_reset("rst_wait_reg");
        @(negedge clk);
        rst     = 1'b0;
        en_a    = 1'b0;
        rd_hold = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/measure_sequencer.md
MEASURE_SEQUENCER -- requirements
Module: measure_sequencer

Interface
REQ-001 SHALL provide parameter NUM_MODES, default 5, number of measurement modes per sweep (1..16).
REQ-002 SHALL provide parameter CH_PER_MODE, default 2, mux channels measured per mode (1..16).
REQ-003 SHALL provide parameter MUX_W, default 3, analog mux select width.
REQ-004 SHALL provide parameter CFG_W, default 8, width of the register word {diapason,keys} written per mode.
REQ-005 SHALL provide parameter SETTLE_PERIODS, default 2, generator periods waited after each mux change (0..255).
REQ-006 SHALL provide parameter DATA_W, default 24, ADC result width.
REQ-007 SHALL provide ports:
  - clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
  - enable  in  1  level; high runs sweeps continuously, low requests stop.
  - gen_new_period  in  1  one-cycle pulse at each generator period start.
  - mode_cfg  in  NUM_MODES*CFG_W  per-mode register word; mode m at [m*CFG_W +: CFG_W].
  - mode_mux  in  NUM_MODES*CH_PER_MODE*MUX_W  mux code; mode m, ch c at [(m*CH_PER_MODE+c)*MUX_W +: MUX_W].
  - reg_start  out  1  one-cycle pulse, starts SPI write of reg_data.
  - reg_data  out  CFG_W  word to SPI master.
  - reg_done  in  1  one-cycle pulse, SPI write finished.
  - cs_sel  out  2  chip select: 3 none, 2 register, 1 DAC.
  - gen_enable  out  1  sine generator enable.
  - mux_chn  out  MUX_W  analog mux select.
  - adc_start  out  1  one-cycle pulse, starts ADC acquisition cycle.
  - adc_complete  in  1  one-cycle pulse, ADC result valid.
  - adc_data  in  DATA_W  ADC result, valid with adc_complete.
  - fifo_wr  out  1  write strobe; fifo_data  out  DATA_W+8  {mode[3:0],ch[3:0],data}.
  - fifo_full  in  1  FIFO cannot accept write.
  - busy  out  1  high when state != IDLE; sweep_done  out  1  one-cycle pulse at end of sweep.
  - overrun  out  1  sticky; set when adc_complete arrives outside WAIT_ADC.

Function
REQ-008 SHALL implement states IDLE, SET_REG, WAIT_REG, GEN_ON, SET_MUX, SETTLE, START_ADC, WAIT_ADC, PUSH, GEN_OFF, NEXT.
REQ-009 IDLE: when enable=1 and gen_new_period=1 SHALL clear mode=0, ch=0 and go to SET_REG next cycle.
REQ-010 SET_REG: cs_sel=2, reg_data=mode_cfg[mode], reg_start pulsed one cycle, -> WAIT_REG.
REQ-011 WAIT_REG: hold until reg_done, then -> GEN_ON; no timeout.
REQ-012 GEN_ON: cs_sel=1, gen_enable=1, -> SET_MUX.
REQ-013 SET_MUX: mux_chn=mode_mux[mode][ch], settle counter=SETTLE_PERIODS, -> SETTLE.
REQ-014 SETTLE: decrement on gen_new_period; leave to START_ADC in the cycle a gen_new_period sees count 0; SETTLE_PERIODS=0 waits for exactly one gen_new_period.
REQ-015 START_ADC: adc_start pulsed one cycle, -> WAIT_ADC.
REQ-016 WAIT_ADC: on adc_complete latch adc_data, mode, ch; -> PUSH.
REQ-017 PUSH: assert fifo_wr one cycle when fifo_full=0; while fifo_full=1 hold, no write, no data loss.
REQ-018 After PUSH: if ch<CH_PER_MODE-1, ch+1 -> SET_MUX; else -> GEN_OFF.
REQ-019 GEN_OFF: gen_enable=0, cs_sel=3, mux_chn=0, -> NEXT.
REQ-020 NEXT: if mode<NUM_MODES-1, mode+1, ch=0 -> SET_REG; else pulse sweep_done, -> IDLE (re-arms on next gen_new_period if enable=1).
REQ-021 enable=0 during any state after WAIT_REG, except WAIT_ADC and PUSH, SHALL jump to GEN_OFF next cycle, then IDLE without sweep_done; WAIT_ADC/PUSH complete their word first.
REQ-022 enable=0 in SET_REG/WAIT_REG SHALL wait for reg_done then go to GEN_OFF.
REQ-023 mode_cfg/mode_mux SHALL be sampled at use; changes mid-sweep affect only later modes/channels.
REQ-024 All outputs SHALL be registered; pulses exactly one clk wide.

Reset
REQ-025 rst SHALL force IDLE, mode=ch=0, settle=0, reg_start=adc_start=fifo_wr=sweep_done=0, gen_enable=0, cs_sel=3, mux_chn=0, reg_data=0, fifo_data=0, busy=0, overrun=0, within one clk, aborting any operation.

Verification
REQ-026 Defaults, enable=1, ideal SPI/ADC, never full -> 10 fifo_wr words, mode/ch tags 0/0,0/1..4/1 in order, 5 reg_start, one sweep_done.
REQ-027 SETTLE_PERIODS=2 -> adc_start occurs after the 3rd gen_new_period following SET_MUX; SETTLE_PERIODS=0 -> after the 1st.
REQ-028 fifo_full held 20 cycles during PUSH -> fifo_wr stays 0, then one write with unchanged fifo_data.
REQ-029 enable dropped in SETTLE of mode 2 -> GEN_OFF next cycle, gen_enable=0, cs_sel=3, mux_chn=0, busy=0 two cycles later, no sweep_done.
REQ-030 adc_complete injected in SETTLE -> overrun=1 sticky until rst; rst mid-WAIT_REG -> all outputs at REQ-025 values next cycle.
